mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for the single shared instruction/data memory of the multicycle CPU. It gives the memory to one requester at a time: port 0 is the CPU memory interface, port 1 is a secondary master such as a program loader or debug/DMA engine. For each transaction it drives a fixed-latency synchronous memory, waits out the latency with a counter, and returns read data with a one-cycle acknowledge.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from memory issue to valid mem_rdata (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req / m1_req  in  1  request; held high until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_be / m1_be  in  DW/8  byte enables
- m0_rdata / m1_rdata  out  DW  registered read data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  latched request fields
- mem_rdata  in  DW  memory read data
- busy  out  1  state ≠ IDLE
- owner  out  1  port currently granted; holds the last grant while IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, pick the winner, latch its we/addr/wdata/be and owner, then go to ISSUE. With no req, stay in IDLE.
- ISSUE: mem_en=1 for exactly one cycle, with mem_* driven from the latched fields. Load cnt = MEM_LAT−1, then go to WAIT.
- WAIT: if cnt≠0, decrement it. If cnt==0, mem_rdata is valid: on a read, load owner's rdata register; then go to DONE.
- DONE: assert ack of owner only for exactly one cycle, then go to IDLE.
- Arbitration default is fixed priority, m0 over m1. A request that loses stays pending without limit.
- A write leaves rdata unchanged. The rdata of the non-owner port never changes.
- The requester samples ack at the clock edge that ends DONE. At that same edge it drops req or presents a new request. A req still high in the following IDLE is treated as a new transaction.
- The arbiter does no alignment or be checks. Fields pass through unchanged.
- Request fields change only in IDLE. After the grant, input changes are ignored until the next IDLE.

## Timing
- Request high in IDLE cycle t gives: ISSUE at t+1, WAIT from t+2 to t+1+MEM_LAT, ack at t+2+MEM_LAT.
- Back-to-back transactions from the same port take MEM_LAT+3 cycles each.
- Reset values: state IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr/wdata/be 0, both rdata 0, busy 0, owner 1. owner=1 makes port 0 the first round-robin winner.
- Reset asserted mid-transaction aborts it immediately and asynchronously. No ack is issued and mem_en drops. The requester must re-request after reset.
- Simultaneous req from both ports in IDLE: the winner is decided by the arbitration mode. The loser is served in the next IDLE if it still requests.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. When both ports request, the grant goes to the port not equal to owner. When only one port requests, that port wins.
- MEM_ARB_RR_EN undefined: fixed priority, m0 always wins.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE/ISSUE/WAIT/DONE, 2 bits)
  - port-ID constants PORT_CPU=0 and PORT_AUX=1
- One sub-module, arb_pick, does the combinational two-way winner selection. Inputs: req[1:0] and last owner. Output: the grant ID. The MEM_ARB_RR_EN selection lives inside it.
- Counter width is $clog2(MEM_LAT+1).

## Test plan
- Single read, MEM_LAT=1: m0 reads 0x10 and the memory returns 0xDEADBEEF. Required: mem_en pulse at t+1, m0_ack at t+3, m0_rdata=0xDEADBEEF, m1_rdata still 0.
- Write, MEM_LAT=3: m1 writes 0x1234 to 0x40 with be=4'b0011. Required: mem_we=1, mem_be=4'b0011, mem_addr=0x40 at the mem_en pulse, m1_ack at t+5, m1_rdata unchanged.
- Contention: both ports request in the same cycle, repeated 4 times.
  - Fixed mode: grant sequence 0,0,0,0 while m0 keeps requesting.
  - RR mode: grant sequence 0,1,0,1.
- Field stability: change m0_addr from 0x10 to 0x20 during WAIT. Required: mem_addr stays 0x10 and the memory sees no second mem_en.
- Reset mid-WAIT, MEM_LAT=4: assert rst during WAIT. Required: busy, mem_en and all acks go to 0 immediately, rdata is 0, and no ack appears after rst is released until a new req.
- Held request: keep m0_req high across its ack. Required: a second transaction starts, ISSUE occurs 2 cycles after the first ack, and a mem_en pulse is generated.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : state encoding and port IDs for the shared-memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick : combinational two-way winner selection (MEM_ARB_RR_EN = round-robin)
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       grant_o
);

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not win last time goes next.
  always_comb begin
    grant_o = req_i[0] ? PORT_CPU : PORT_AUX;
    if (req_i == 2'b11) begin
      grant_o = ~last_owner_i;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    grant_o = req_i[0] ? PORT_CPU : PORT_AUX;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port arbiter/sequencer for a fixed-latency shared memory
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_ack,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_ack,

  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,

  output logic            busy,
  output logic            owner
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_e            state_q;
  logic              owner_q;
  logic              owner_d;
  logic [CW-1:0]     cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic [DW/8-1:0]   mem_be_q;
  logic [1:0]        ack_q;
  logic [DW-1:0]     rdata0_q;
  logic [DW-1:0]     rdata1_q;

  arb_pick u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_owner_i (owner_q),
    .grant_o      (owner_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_AUX;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      ack_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      mem_en_q <= 1'b0;
      ack_q    <= '0;
      case (state_q)
        IDLE: begin
          // Request fields are captured only here; later input changes are ignored.
          if (m0_req || m1_req) begin
            owner_q     <= owner_d;
            mem_we_q    <= (owner_d == PORT_AUX) ? m1_we    : m0_we;
            mem_addr_q  <= (owner_d == PORT_AUX) ? m1_addr  : m0_addr;
            mem_wdata_q <= (owner_d == PORT_AUX) ? m1_wdata : m0_wdata;
            mem_be_q    <= (owner_d == PORT_AUX) ? m1_be    : m0_be;
            mem_en_q    <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!mem_we_q) begin
              if (owner_q == PORT_AUX) begin
                rdata1_q <= mem_rdata;
              end else begin
                rdata0_q <= mem_rdata;
              end
            end
            ack_q[owner_q] <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

`default_nettype wire
